// File: rtl/bounded_down_counter.sv
// bounded_down_counter
//
// Loadable down-counter that runs from a loaded start value toward the lower
// bound LOW of the window [LOW, HIGH], then stops on its own. A start/busy/done
// handshake lets a controller launch a countdown and detect completion without
// watching the count value.
//
// Parameters:
//   WIDTH - width of count and load_val
//   LOW   - lower bound of the legal window; the value the count ends on
//   HIGH  - upper bound of the legal window; the reset value of count
//   STEP  - decrement applied on each enabled cycle while running
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous, active-low reset
//   start    - launch request, sampled only while idle
//   load_val - start value, captured when start is accepted
//   enable   - advances the count while running; low pauses it
//   abort    - cancels a run in progress, leaving count where it is
//   count    - current count (registered)
//   busy     - high while a countdown is running
//   done     - one-cycle pulse when a countdown reaches LOW (registered)
//   err      - sticky flag set by a start with load_val outside the window

module bounded_down_counter #(
    parameter int WIDTH = 8,
    parameter int LOW   = 5,
    parameter int HIGH  = 67,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [WIDTH-1:0] LOW_W  = WIDTH'(LOW);
    localparam logic [WIDTH-1:0] HIGH_W = WIDTH'(HIGH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Comparisons are carried out one bit wider than the count so that
    // LOW+STEP can never wrap and make a small count look large.
    localparam logic [WIDTH:0] LOW_X       = (WIDTH+1)'(LOW);
    localparam logic [WIDTH:0] HIGH_X      = (WIDTH+1)'(HIGH);
    localparam logic [WIDTH:0] THRESHOLD_X = (WIDTH+1)'(LOW + STEP);

    state_t state;

    logic [WIDTH:0] count_x;
    logic [WIDTH:0] load_x;
    logic           load_ok;
    logic           can_step;

    assign count_x  = {1'b0, count};
    assign load_x   = {1'b0, load_val};
    assign load_ok  = (load_x >= LOW_X) && (load_x <= HIGH_X);
    // A full STEP still lands at or above LOW; otherwise this is the last edge.
    assign can_step = (count_x >= THRESHOLD_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= HIGH_W;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            // done is a pulse: it drops again on every edge unless the
            // terminal branch below re-asserts it.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (load_ok) begin
                            count <= load_val;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // abort takes priority over both a normal step and the
                    // terminal step, and never produces a done pulse.
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (enable) begin
                        if (can_step) begin
                            count <= count - STEP_W;
                        end else begin
                            count <= LOW_W;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/bounded_down_counter.md
Name: bounded_down_counter

Overview:
- Loadable down-counter that runs from a loaded start value toward a lower bound LOW, then self-terminates.
- Complements the existing bounded up-counter: together they provide both count directions within the window [LOW, HIGH].
- Uses a start/busy/done handshake so that a controller or testbench block can launch a countdown and detect completion without polling the count value.

Parameters:
- WIDTH, 8, width of count and load_val.
- LOW, 5, lower bound of the legal window; termination target.
- HIGH, 67, upper bound of the legal window; the reset value of count.
- STEP, 1, decrement per enabled cycle. Legal settings: 1 <= STEP, LOW <= HIGH, HIGH < 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- load_val  input  WIDTH  start value, captured when start is accepted.
- enable  input  1  count-advance qualifier while RUN; low pauses the count.
- abort  input  1  cancels a RUN in progress.
- count  output  WIDTH  current count (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse (registered).
- err  output  1  sticky flag for an out-of-window load.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, asynchronous): state=IDLE, count=HIGH, busy=0, done=0, err=0. A reset during RUN discards the run immediately; no done pulse is produced.
- States: IDLE, RUN. done is a registered pulse, not a separate state.
- IDLE, start=1, LOW <= load_val <= HIGH:
  - next edge: count<=load_val, err<=0, busy<=1, state<=RUN.
- IDLE, start=1, load_val outside the window:
  - count holds, err<=1, state stays IDLE.
  - err stays high until the next accepted start or reset.
- IDLE, start=0: all outputs hold; done=0.
- RUN, enable=1, abort=0:
  - Compare in WIDTH+1 bits so no wrap-around can occur.
  - If count >= LOW+STEP: count<=count-STEP.
  - Otherwise (terminal): count<=LOW, busy<=0, done<=1 for exactly one cycle, state<=IDLE.
- RUN, enable=0, abort=0: count holds, busy stays 1, no termination.
- RUN, abort=1: state<=IDLE, busy<=0, count holds its current value, done=0. abort wins over both enable and terminal in the same cycle.
- start while in RUN is ignored; load_val is not sampled.
- start in the same cycle that done is high: the block is already in IDLE, so the start is accepted normally (back-to-back runs allowed).
- abort in IDLE has no effect.
- Latency and cycle counts:
  - The start edge loads the counter; the first decrement occurs on the next enabled edge.
  - Enabled edges from load to done = floor((load_val-LOW)/STEP) + 1.
  - Example: load_val=LOW terminates after 1 enabled edge.
- Overflow: count never leaves [LOW, HIGH] while in RUN. Underflow is impossible because of the WIDTH+1 comparison.

Test Plan:
- Reset mid-run: start load_val=20, run 3 enabled cycles, assert rst_n=0 -> count=67, busy=0, done=0, err=0 asynchronously, with no done pulse afterward.
- Full run with defaults:
  - start load_val=67, enable held high.
  - count goes 67,66,...,5; done=1 for one cycle on the 63rd enabled edge after load; count=5, busy=0.
- STEP=4, load_val=18: count 18,14,10,6, then terminal -> count=5, done pulse on the 4th enabled edge.
- Pause and abort:
  - load 30 and toggle enable 1,0,0,1 -> count 29 held for 2 cycles, then 28.
  - abort with enable=1 at count=25 -> count stays 25, busy=0, no done.
- Range check:
  - start load_val=4 -> err=1, state IDLE, count unchanged.
  - start load_val=68 -> err remains 1.
  - start load_val=10 -> err=0, busy=1.
- Handshake corners:
  - start during RUN is ignored (count unaffected).
  - start asserted in the done cycle with load_val=7 -> accepted; count=7, busy=1 on the next edge.
